// File: rtl/can_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : can_pkg
//  Description : Shared types and constants for the CAN 2.0A frame
//                transmitter: FSM state encoding, CRC-15 polynomial, fixed
//                field lengths and a serial CRC step helper.
//  Revision    : 1.0 - initial release
// ============================================================================
package can_pkg;

    typedef enum logic [3:0] {
        ST_IDLE     = 4'd0,
        ST_SOF      = 4'd1,
        ST_ARB      = 4'd2,
        ST_CTRL     = 4'd3,
        ST_DATA     = 4'd4,
        ST_CRC      = 4'd5,
        ST_CRC_DEL  = 4'd6,
        ST_ACK_SLOT = 4'd7,
        ST_ACK_DEL  = 4'd8,
        ST_EOF      = 4'd9,
        ST_IFS      = 4'd10,
        ST_RETX     = 4'd11
    } can_state_e;

    localparam logic [14:0] CAN_CRC_POLY = 15'h4599;
    localparam int          CAN_CTRL_LEN = 6;
    localparam int          CAN_CRC_LEN  = 15;
    localparam int          CAN_EOF_LEN  = 7;

    // Arbitration field is the identifier followed by the RTR bit.
    function automatic int can_arb_len(input int id_w);
        return id_w + 1;
    endfunction

    // One serial CRC-15 update step (MSB-first shift register).
    function automatic logic [14:0] can_crc15_step(input logic [14:0] crc,
                                                   input logic        b);
        logic       fb;
        logic [14:0] nxt;
        fb  = b ^ crc[14];
        nxt = {crc[13:0], 1'b0};
        if (fb) begin
            nxt = nxt ^ CAN_CRC_POLY;
        end
        return nxt;
    endfunction

endpackage
`default_nettype wire

// File: rtl/can_crc15.sv
`default_nettype none
// ============================================================================
//  Module      : can_crc15
//  Description : Serial CRC-15 accumulator. Cleared by init, advanced by one
//                bit whenever en is high. The owner only enables it on
//                unstuffed frame bits.
//  Revision    : 1.0 - initial release
// ============================================================================
module can_crc15
    import can_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        init,
    input  logic        en,
    input  logic        bit_in,
    output logic [14:0] crc
);

    logic [14:0] r_crc;

    // Clear on reset/init, otherwise fold in one bit per enable.
    always_ff @(posedge clk) begin
        if (rst || init) begin
            r_crc <= '0;
        end else if (en) begin
            r_crc <= can_crc15_step(r_crc, bit_in);
        end
    end

    assign crc = r_crc;

endmodule
`default_nettype wire

// File: rtl/can_frame_tx.sv
`default_nettype none
// ============================================================================
//  Module      : can_frame_tx
//  Description : CAN 2.0A base data-frame transmitter with bit stuffing,
//                readback arbitration and ACK-slot checking. Payload length
//                is min(dlc, MAX_BYTES); the raw dlc is transmitted.
//                Optional macro CAN_TX_AUTO_RETX_EN enables automatic retry
//                after lost arbitration or a missing ACK.
//  Revision    : 1.0 - initial release
// ============================================================================
module can_frame_tx
    import can_pkg::*;
#(
    parameter int ID_W      = 11,
    parameter int MAX_BYTES = 8,
    parameter int STUFF_LEN = 5,
    parameter int IFS_BITS  = 3
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   baud_tick,
    input  logic                   send_data,
    input  logic [ID_W-1:0]        address,
    input  logic [3:0]             dlc,
    input  logic [MAX_BYTES*8-1:0] data,
    input  logic                   rx,
    output logic                   tx,
    output logic                   txing,
    output logic                   can_bitstuff,
    output logic                   arb_lost,
    output logic                   done,
    output logic                   ack_ok
);

    localparam int c_arb_len = can_arb_len(ID_W);
    localparam int c_data_w  = MAX_BYTES * 8;
    localparam int c_cnt_w   = $clog2(c_data_w + ID_W + 32);
    localparam int c_run_w   = $clog2(STUFF_LEN + 1);
    localparam int c_id_iw   = $clog2(ID_W);
    localparam int c_didx_w  = $clog2(c_data_w);

    // State and cnt always name the most recent unstuffed bit; a stuff bit
    // leaves them untouched so the next advance continues the field.
    can_state_e            r_state;
    logic [c_cnt_w-1:0]    r_cnt;
    logic [c_run_w-1:0]    r_run;
    logic                  r_armed;
    logic [ID_W-1:0]       r_id;
    logic [3:0]            r_dlc;
    logic [c_data_w-1:0]   r_data;
    logic                  r_tx;
    logic                  r_txing;
    logic                  r_stuff;
    logic                  r_arb_lost;
    logic                  r_done;
    logic                  r_ack_ok;

    logic [14:0]           w_crc;
    logic [c_cnt_w-1:0]    w_cnt_inc;
    logic [c_cnt_w-1:0]    w_nbytes;
    logic [c_cnt_w-1:0]    w_data_last;
    logic [c_id_iw-1:0]    w_id_idx;
    logic [1:0]            w_dlc_idx;
    logic [c_didx_w-1:0]   w_data_idx;
    logic [3:0]            w_crc_idx;
    can_state_e            w_nxt_state;
    logic [c_cnt_w-1:0]    w_nxt_cnt;
    logic                  w_nxt_bit;
    logic                  w_nxt_crc_en;
    logic                  w_in_frame;
    logic                  w_in_stuff;
    logic                  w_stuff_due;
    logic                  w_arb_loss;
    logic                  w_advance;
    logic                  w_crc_en;
    logic                  w_crc_init;

    assign w_cnt_inc   = r_cnt + c_cnt_w'(1);
    assign w_nbytes    = (c_cnt_w'(r_dlc) > c_cnt_w'(MAX_BYTES)) ? c_cnt_w'(MAX_BYTES)
                                                                 : c_cnt_w'(r_dlc);
    assign w_data_last = (w_nbytes << 3) - c_cnt_w'(1);

    // Bit pointers for the next position inside each field.
    assign w_id_idx    = c_id_iw'(ID_W - 1) - c_id_iw'(w_cnt_inc);
    assign w_dlc_idx   = 2'(c_cnt_w'(5) - w_cnt_inc);
    assign w_data_idx  = c_didx_w'(w_cnt_inc) ^ c_didx_w'(7);
    assign w_crc_idx   = 4'd14 - 4'(w_cnt_inc);

    assign w_in_frame  = (r_state != ST_IDLE) && (r_state != ST_RETX);
    assign w_in_stuff  = (r_state == ST_SOF) || (r_state == ST_ARB) ||
                         (r_state == ST_CTRL) || (r_state == ST_DATA) ||
                         (r_state == ST_CRC);
    assign w_stuff_due = w_in_stuff && (r_run == c_run_w'(STUFF_LEN));
    assign w_arb_loss  = baud_tick && (r_state == ST_ARB) && r_tx && !rx;
    assign w_advance   = baud_tick && w_in_frame && !w_arb_loss && !w_stuff_due;

    // SOF is dominant and the CRC starts at zero, so skipping it is exact.
    assign w_crc_en    = w_advance && w_nxt_crc_en;
    assign w_crc_init  = (r_state == ST_IDLE) || (r_state == ST_RETX);

    can_crc15 u_crc (
        .clk    (clk),
        .rst    (rst),
        .init   (w_crc_init),
        .en     (w_crc_en),
        .bit_in (w_nxt_bit),
        .crc    (w_crc)
    );

    // Next unstuffed bit position and value after the current one.
    always_comb begin
        w_nxt_state  = r_state;
        w_nxt_cnt    = w_cnt_inc;
        w_nxt_bit    = 1'b1;
        w_nxt_crc_en = 1'b0;
        case (r_state)
            ST_SOF: begin
                w_nxt_state  = ST_ARB;
                w_nxt_cnt    = '0;
                w_nxt_bit    = r_id[ID_W-1];
                w_nxt_crc_en = 1'b1;
            end
            ST_ARB: begin
                w_nxt_crc_en = 1'b1;
                if (r_cnt == c_cnt_w'(c_arb_len - 1)) begin
                    w_nxt_state = ST_CTRL;
                    w_nxt_cnt   = '0;
                    w_nxt_bit   = 1'b0;
                end else if (w_cnt_inc < c_cnt_w'(ID_W)) begin
                    w_nxt_bit = r_id[w_id_idx];
                end else begin
                    w_nxt_bit = 1'b0;
                end
            end
            ST_CTRL: begin
                if (r_cnt == c_cnt_w'(CAN_CTRL_LEN - 1)) begin
                    w_nxt_cnt = '0;
                    if (w_nbytes != '0) begin
                        w_nxt_state  = ST_DATA;
                        w_nxt_bit    = r_data[7];
                        w_nxt_crc_en = 1'b1;
                    end else begin
                        w_nxt_state = ST_CRC;
                        w_nxt_bit   = w_crc[14];
                    end
                end else begin
                    w_nxt_crc_en = 1'b1;
                    w_nxt_bit    = (w_cnt_inc < c_cnt_w'(2)) ? 1'b0 : r_dlc[w_dlc_idx];
                end
            end
            ST_DATA: begin
                if (r_cnt == w_data_last) begin
                    w_nxt_state = ST_CRC;
                    w_nxt_cnt   = '0;
                    w_nxt_bit   = w_crc[14];
                end else begin
                    w_nxt_bit    = r_data[w_data_idx];
                    w_nxt_crc_en = 1'b1;
                end
            end
            ST_CRC: begin
                if (r_cnt == c_cnt_w'(CAN_CRC_LEN - 1)) begin
                    w_nxt_state = ST_CRC_DEL;
                    w_nxt_cnt   = '0;
                end else begin
                    w_nxt_bit = w_crc[w_crc_idx];
                end
            end
            ST_CRC_DEL: begin
                w_nxt_state = ST_ACK_SLOT;
                w_nxt_cnt   = '0;
            end
            ST_ACK_SLOT: begin
                w_nxt_state = ST_ACK_DEL;
                w_nxt_cnt   = '0;
            end
            ST_ACK_DEL: begin
                w_nxt_state = ST_EOF;
                w_nxt_cnt   = '0;
            end
            ST_EOF: begin
                if (r_cnt == c_cnt_w'(CAN_EOF_LEN - 1)) begin
                    w_nxt_state = ST_IFS;
                    w_nxt_cnt   = '0;
                end
            end
            ST_IFS: begin
                if (r_cnt == c_cnt_w'(IFS_BITS - 1)) begin
                    w_nxt_state = ST_IDLE;
                    w_nxt_cnt   = '0;
                end
            end
            default: begin
                w_nxt_state = r_state;
            end
        endcase
    end

    // Frame FSM: request latch, bit sequencing, stuffing, arbitration, ACK.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= ST_IDLE;
            r_cnt      <= '0;
            r_run      <= '0;
            r_armed    <= 1'b0;
            r_id       <= '0;
            r_dlc      <= '0;
            r_data     <= '0;
            r_tx       <= 1'b1;
            r_txing    <= 1'b0;
            r_stuff    <= 1'b0;
            r_arb_lost <= 1'b0;
            r_done     <= 1'b0;
            r_ack_ok   <= 1'b0;
        end else begin
            r_arb_lost <= 1'b0;
            r_done     <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (!r_armed && send_data) begin
                        r_armed  <= 1'b1;
                        r_id     <= address;
                        r_dlc    <= dlc;
                        r_data   <= data;
                        r_ack_ok <= 1'b0;
                    end else if (r_armed && baud_tick) begin
                        r_armed <= 1'b0;
                        r_state <= ST_SOF;
                        r_cnt   <= '0;
                        r_tx    <= 1'b0;
                        r_txing <= 1'b1;
                        r_stuff <= 1'b0;
                        r_run   <= c_run_w'(1);
                    end
                end
`ifdef CAN_TX_AUTO_RETX_EN
                ST_RETX: begin
                    r_txing <= 1'b1;
                    if (baud_tick) begin
                        if (r_cnt == '0) begin
                            r_state <= ST_SOF;
                            r_tx    <= 1'b0;
                            r_stuff <= 1'b0;
                            r_run   <= c_run_w'(1);
                        end else begin
                            r_cnt <= r_cnt - c_cnt_w'(1);
                        end
                    end
                end
`endif
                default: begin
                    if (baud_tick) begin
                        if (w_arb_loss) begin
                            r_arb_lost <= 1'b1;
                            r_tx       <= 1'b1;
                            r_txing    <= 1'b0;
                            r_stuff    <= 1'b0;
`ifdef CAN_TX_AUTO_RETX_EN
                            // Wait out three recessive bits, then retry.
                            r_state    <= ST_RETX;
                            r_cnt      <= c_cnt_w'(2);
`else
                            r_state    <= ST_IDLE;
                            r_cnt      <= '0;
`endif
                        end else if (w_stuff_due) begin
                            r_tx    <= ~r_tx;
                            r_stuff <= 1'b1;
                            r_run   <= c_run_w'(1);
                        end else begin
                            r_stuff <= 1'b0;
                            r_tx    <= w_nxt_bit;
                            r_state <= w_nxt_state;
                            r_cnt   <= w_nxt_cnt;
                            if (w_nxt_bit == r_tx) begin
                                if (r_run < c_run_w'(STUFF_LEN)) begin
                                    r_run <= r_run + c_run_w'(1);
                                end
                            end else begin
                                r_run <= c_run_w'(1);
                            end
                            if (r_state == ST_ACK_SLOT) begin
                                r_ack_ok <= ~rx;
                            end
                            if (w_nxt_state == ST_IDLE) begin
                                r_done  <= 1'b1;
                                r_txing <= 1'b0;
`ifdef CAN_TX_AUTO_RETX_EN
                                if (!r_ack_ok) begin
                                    r_state <= ST_RETX;
                                    r_cnt   <= '0;
                                end
`endif
                            end
                        end
                    end
                end
            endcase
        end
    end

    assign tx           = r_tx;
    assign txing        = r_txing;
    assign can_bitstuff = r_stuff;
    assign arb_lost     = r_arb_lost;
    assign done         = r_done;
    assign ack_ok       = r_ack_ok;

endmodule
`default_nettype wire

// File: tb/tb_can_frame_tx.sv
`default_nettype none
// ============================================================================
//  Module      : tb_can_frame_tx
//  Description : Directed self-checking bench for can_frame_tx. A reference
//                frame builder produces the expected stuffed bit stream for
//                each vector; the bus readback mirrors tx unless overridden.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_can_frame_tx;

    logic        clk = 1'b0;
    logic        rst;
    logic        baud_tick = 1'b0;
    logic        send_data;
    logic [10:0] address;
    logic [3:0]  dlc;
    logic [63:0] data;
    logic        rx;
    logic        tx, txing, can_bitstuff, arb_lost, done, ack_ok;
    logic        rx_force, rx_val;

    int checks   = 0;
    int failures = 0;
    int div      = 0;

    logic exp_bits [0:255];
    logic exp_stf  [0:255];
    logic ub       [0:255];
    int   un, exp_len, ack_idx, exp_nstf;
    int   n_plain, n_stf, first_stf;

    assign rx = rx_force ? rx_val : tx;

    can_frame_tx dut (
        .clk          (clk),
        .rst          (rst),
        .baud_tick    (baud_tick),
        .send_data    (send_data),
        .address      (address),
        .dlc          (dlc),
        .data         (data),
        .rx           (rx),
        .tx           (tx),
        .txing        (txing),
        .can_bitstuff (can_bitstuff),
        .arb_lost     (arb_lost),
        .done         (done),
        .ack_ok       (ack_ok)
    );

    always #5 clk = ~clk;

    // One bit time every four clocks.
    always @(negedge clk) begin
        div       = (div == 3) ? 0 : div + 1;
        baud_tick = (div == 0);
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic wait_tick();
        do @(posedge clk); while (baud_tick !== 1'b1);
        #1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic push_u(input logic b);
        ub[un] = b;
        un++;
    endtask

    task automatic push_e(input logic b, input logic s);
        exp_bits[exp_len] = b;
        exp_stf[exp_len]  = s;
        exp_len++;
    endtask

    // Reference frame: unstuffed SOF..CRC, then stuffing, then the trailer.
    task automatic build(input logic [10:0] id, input logic [3:0] d, input logic [63:0] pl);
        logic [14:0] crc;
        logic        fb, last;
        int          nb, run, n_crc;
        un = 0;
        push_u(1'b0);
        for (int k = 10; k >= 0; k--) push_u(id[k]);
        push_u(1'b0); push_u(1'b0); push_u(1'b0);
        for (int k = 3; k >= 0; k--) push_u(d[k]);
        nb = (d > 4'd8) ? 8 : int'(d);
        for (int by = 0; by < nb; by++)
            for (int k = 7; k >= 0; k--) push_u(pl[by*8 + k]);
        crc   = 15'h0;
        n_crc = un;
        for (int j = 0; j < n_crc; j++) begin
            fb  = ub[j] ^ crc[14];
            crc = {crc[13:0], 1'b0};
            if (fb) crc = crc ^ 15'h4599;
        end
        for (int k = 14; k >= 0; k--) push_u(crc[k]);
        exp_len  = 0;
        exp_nstf = 0;
        run      = 0;
        last     = 1'b1;
        for (int j = 0; j < un; j++) begin
            push_e(ub[j], 1'b0);
            run  = (ub[j] == last) ? run + 1 : 1;
            last = ub[j];
            if (run == 5) begin
                push_e(~last, 1'b1);
                last = ~last;
                run  = 1;
                exp_nstf++;
            end
        end
        push_e(1'b1, 1'b0);
        ack_idx = exp_len;
        push_e(1'b1, 1'b0);
        push_e(1'b1, 1'b0);
        for (int k = 0; k < 10; k++) push_e(1'b1, 1'b0);
    endtask

    task automatic start_req(input logic [10:0] id, input logic [3:0] d, input logic [63:0] pl);
        @(negedge clk);
        address   = id;
        dlc       = d;
        data      = pl;
        send_data = 1'b1;
        @(negedge clk);
        send_data = 1'b0;
    endtask

    // Send one frame and compare every bit time against the reference.
    task automatic run_frame(input logic [10:0] id, input logic [3:0] d, input logic [63:0] pl,
                             input bit ack, input int poke_at, input int rst_at);
        bit aborted;
        aborted   = 1'b0;
        n_plain   = 0;
        n_stf     = 0;
        first_stf = -1;
        build(id, d, pl);
        start_req(id, d, pl);
        chk("pre_sof_tx", tx, 1);
        for (int i = 0; i < exp_len; i++) begin
            wait_tick();
            chk($sformatf("tx[%0d]", i), tx, exp_bits[i]);
            chk($sformatf("stuff[%0d]", i), can_bitstuff, exp_stf[i]);
            chk($sformatf("txing[%0d]", i), txing, 1);
            if (can_bitstuff === 1'b1) begin
                n_stf++;
                if (first_stf < 0) first_stf = i;
            end else begin
                n_plain++;
            end
            rx_force = ack && (i == ack_idx);
            rx_val   = 1'b0;
            if (i == poke_at) begin
                @(negedge clk);
                address   = ~id;
                send_data = 1'b1;
                @(negedge clk);
                send_data = 1'b0;
            end
            if (i == rst_at) begin
                @(negedge clk);
                rst = 1'b1;
                @(posedge clk);
                #1;
                rst = 1'b0;
                chk("abort_tx", tx, 1);
                chk("abort_txing", txing, 0);
                chk("abort_stuff", can_bitstuff, 0);
                chk("abort_done", done, 0);
                aborted = 1'b1;
                break;
            end
        end
        rx_force = 1'b0;
        if (!aborted) begin
            wait_tick();
            chk("done_pulse", done, 1);
            chk("done_txing", txing, 0);
            chk("done_ack_ok", ack_ok, ack);
            chk("done_arb", arb_lost, 0);
            @(posedge clk);
            #1;
            chk("done_clear", done, 0);
        end
    endtask

    initial begin
        rst       = 1'b1;
        send_data = 1'b0;
        address   = '0;
        dlc       = '0;
        data      = '0;
        rx_force  = 1'b0;
        rx_val    = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst_tx", tx, 1);
        chk("rst_txing", txing, 0);
        chk("rst_stuff", can_bitstuff, 0);
        chk("rst_arb", arb_lost, 0);
        chk("rst_done", done, 0);
        chk("rst_ack", ack_ok, 0);
        rst = 1'b0;

        // T1: all-zero frame, first stuff bit after SOF + 4 zero ID bits.
        run_frame(11'h000, 4'd0, 64'h0, 1'b0, -1, -1);
        chk("t1_first_stuff", first_stf, 5);
        do_reset();

        // T2: two-byte payload.
        run_frame(11'h123, 4'd2, 64'hA55A, 1'b0, -1, -1);
        chk("t2_plain_bits", n_plain, 63);
        chk("t2_stuff_bits", n_stf, exp_nstf);
        do_reset();

        // T3: arbitration loss on the first ID bit.
        start_req(11'h7FF, 4'd0, 64'h0);
        wait_tick();
        chk("t3_sof", tx, 0);
        wait_tick();
        chk("t3_id0", tx, 1);
        rx_force = 1'b1;
        rx_val   = 1'b0;
        wait_tick();
        rx_force = 1'b0;
        chk("t3_arb_lost", arb_lost, 1);
        chk("t3_tx", tx, 1);
        chk("t3_txing", txing, 0);
        chk("t3_done", done, 0);
        @(posedge clk);
        #1;
        chk("t3_arb_clear", arb_lost, 0);
`ifdef CAN_TX_AUTO_RETX_EN
        chk("t3r_txing_back", txing, 1);
        wait_tick();
        chk("t3r_rec1", tx, 1);
        wait_tick();
        chk("t3r_rec2", tx, 1);
        wait_tick();
        chk("t3r_sof", tx, 0);
        chk("t3r_sof_txing", txing, 1);
`else
        chk("t3_txing_low", txing, 0);
        repeat (4) begin
            wait_tick();
            chk("t3_idle_tx", tx, 1);
            chk("t3_idle_txing", txing, 0);
            chk("t3_idle_done", done, 0);
        end
`endif
        do_reset();

        // T4: dominant ACK, then the same frame without ACK.
        run_frame(11'h456, 4'd1, 64'h3C, 1'b1, -1, -1);
        do_reset();
        run_frame(11'h456, 4'd1, 64'h3C, 1'b0, -1, -1);
        do_reset();

        // T5: dlc clamp to 8 bytes, mid-frame request ignored.
        run_frame(11'h2AA, 4'd15, 64'h0123456789ABCDEF, 1'b1, 30, -1);
        chk("t5_plain_bits", n_plain, 111);
        repeat (3) begin
            wait_tick();
            chk("t5_idle_tx", tx, 1);
            chk("t5_idle_txing", txing, 0);
        end
        do_reset();

        // T6: reset in the middle of DATA, then a clean frame.
        run_frame(11'h123, 4'd2, 64'hA55A, 1'b0, -1, 25);
        repeat (2) begin
            wait_tick();
            chk("t6_idle_tx", tx, 1);
            chk("t6_idle_txing", txing, 0);
        end
        run_frame(11'h123, 4'd2, 64'hA55A, 1'b1, -1, -1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
